// File: rtl/ctrl_pkg.sv
// Shared types and default sizing for the counter load-port controller.
package ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } ctrl_state_t;

    localparam int unsigned DefNumReq  = 4;
    localparam int unsigned DefCntW    = 4;
    localparam int unsigned DefHoldCyc = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest set request at or above ptr, else lowest overall.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt_onehot,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int unsigned IdW = $clog2(N);

    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] sel;

    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(N); i++) begin
            mask[i] = (i >= int'(ptr));
        end
        masked = req & mask;
        // Fall back to the unmasked vector when nothing sits at or above ptr (wrap-around).
        sel        = (|masked) ? masked : req;
        gnt_onehot = sel & (~sel + {{(N-1){1'b0}}, 1'b1});
        gnt_idx    = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (gnt_onehot[i]) begin
                gnt_idx = IdW'(i);
            end
        end
    end

endmodule

// File: rtl/counter_load_ctrl.sv
// Round-robin front end sharing the load port of a loadable up-counter among NUM_REQ
// requesters, with a fixed free-run window after every load.
module counter_load_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ  = DefNumReq,
    parameter int unsigned CNT_W    = DefCntW,
    parameter int unsigned HOLD_CYC = DefHoldCyc
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*CNT_W-1:0]   req_val_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       load_o,
    output logic [CNT_W-1:0]           load_val_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o
);
    localparam int unsigned IdW   = $clog2(NUM_REQ);
    localparam int unsigned HoldW = $clog2(HOLD_CYC + 1);

    ctrl_state_t        state_q, state_d;
    logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]     grant_id_q, grant_id_d;
    logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]   val_q, val_d;
    logic               load_q, load_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;

    logic [NUM_REQ-1:0] gnt_onehot;
    logic [IdW-1:0]     gnt_idx;
    logic [CNT_W-1:0]   win_val;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req        (req_valid_i),
        .ptr        (rr_ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    always_comb begin
        win_val = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt_onehot[i]) begin
                win_val = req_val_i[i*CNT_W +: CNT_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        hold_cnt_d = hold_cnt_q;
        val_d      = val_q;
        load_d     = 1'b0;
        ready_d    = '0;
        unique case (state_q)
            IDLE: begin
                // Strobe and ack are computed here so they leave as flop outputs in LOAD.
                if (|req_valid_i) begin
                    state_d    = LOAD;
                    grant_id_d = gnt_idx;
                    val_d      = win_val;
                    load_d     = 1'b1;
                    ready_d    = gnt_onehot;
                end
            end
            LOAD: begin
                rr_ptr_d   = (grant_id_q == IdW'(NUM_REQ - 1)) ? '0 : grant_id_q + IdW'(1);
                hold_cnt_d = HoldW'(HOLD_CYC - 1);
                state_d    = HOLD;
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HoldW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            hold_cnt_q <= '0;
            val_q      <= '0;
            load_q     <= 1'b0;
            ready_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            hold_cnt_q <= hold_cnt_d;
            val_q      <= val_d;
            load_q     <= load_d;
            ready_q    <= ready_d;
        end
    end

    assign load_o      = load_q;
    assign req_ready_o = ready_q;
    assign load_val_o  = load_q ? val_q : '0;
    assign grant_id_o  = grant_id_q;
    assign busy_o      = (state_q != IDLE);

endmodule
